// File: rtl/switches_poller_pkg.sv
// switches_poller_pkg
// Shared definitions for the switches poller slice: poll FSM state encoding
// and the PIO register address the poller reads.
package switches_poller_pkg;

  // Address of the data register in the switches PIO.
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  // Width of the debounce counter (DEBOUNCE_N is limited to 1..255).
  localparam int DEB_CNT_W = 8;

  // Poll sequence: IDLE waits for a tick, READ issues the bus read, CAPTURE
  // registers the returned data, EVAL runs the debounce step.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    EVAL    = 2'd3
  } poll_state_e;

endpackage

// File: rtl/switches_poller_if.sv
// switches_poller_if
// Bundles the Avalon-MM read master toward the switches PIO and the
// valid/ready change-event channel toward the consumer.
//   master modport : the poller (drives avm_address/avm_read and evt_*)
//   slave modport  : the PIO plus event consumer (drives avm_readdata, evt_ready)
// Parameter WIDTH : number of switch bits carried by the event fields.
interface switches_poller_if #(
  parameter int WIDTH = 4
);

  logic [1:0]       avm_address;
  logic             avm_read;
  logic [31:0]      avm_readdata;
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_state;
  logic [WIDTH-1:0] evt_rise;
  logic [WIDTH-1:0] evt_fall;
  logic             evt_overflow;

  modport master (
    output avm_address, avm_read,
    input  avm_readdata,
    output evt_valid, evt_state, evt_rise, evt_fall, evt_overflow,
    input  evt_ready
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_readdata,
    input  evt_valid, evt_state, evt_rise, evt_fall, evt_overflow,
    output evt_ready
  );

endinterface

// File: rtl/switches_poller_debounce.sv
// switches_poller_debounce
// Debounce step executed once per poll. A new sample must repeat DEBOUNCE_N
// consecutive polls before it replaces the stable state.
//   clk, reset_n   : clock, synchronous active-low reset
//   eval_i         : one-cycle strobe, run one debounce step on sample_i
//   sample_i       : latest polled switch value
//   stable_o       : current debounced state
//   stable_next_o  : debounced state after this cycle's step
//   change_o       : stable state changes at the end of this cycle
module switches_poller_debounce
  import switches_poller_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEBOUNCE_N = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             eval_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] stable_next_o,
  output logic             change_o
);

  localparam logic [DEB_CNT_W-1:0] DEB_TARGET = DEB_CNT_W'(DEBOUNCE_N);

  logic [WIDTH-1:0]     stable_q, stable_d;
  logic [WIDTH-1:0]     candidate_q, candidate_d;
  logic [DEB_CNT_W-1:0] count_q, count_d;
  logic                 change_s;

  // Next-state for candidate/count/stable on an evaluation strobe.
  always_comb begin
    stable_d    = stable_q;
    candidate_d = candidate_q;
    count_d     = count_q;
    change_s    = 1'b0;
    if (eval_i) begin
      if (sample_i == stable_q) begin
        // Input is back at the accepted state: abandon any pending change.
        count_d = {DEB_CNT_W{1'b0}};
      end else if (sample_i == candidate_q) begin
        count_d = count_q + 8'd1;
      end else begin
        candidate_d = sample_i;
        count_d     = 8'd1;
      end
      // Uses the freshly computed candidate so DEBOUNCE_N=1 accepts at once.
      if (count_d == DEB_TARGET) begin
        stable_d = candidate_d;
        count_d  = {DEB_CNT_W{1'b0}};
        change_s = 1'b1;
      end else begin
        change_s = 1'b0;
      end
    end else begin
      change_s = 1'b0;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable_q    <= {WIDTH{1'b0}};
      candidate_q <= {WIDTH{1'b0}};
      count_q     <= {DEB_CNT_W{1'b0}};
    end else begin
      stable_q    <= stable_d;
      candidate_q <= candidate_d;
      count_q     <= count_d;
    end
  end

  assign stable_o      = stable_q;
  assign stable_next_o = stable_d;
  assign change_o      = change_s;

endmodule

// File: rtl/switches_poller.sv
// switches_poller
// Periodically reads a switches PIO over Avalon-MM, debounces the value and
// publishes change events (new state, rising and falling bits) on a
// valid/ready channel. Changes arriving while an event is still pending are
// merged into it and flagged with a sticky overflow bit.
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset
//   enable   : polling enable; low keeps the FSM idle once a poll finishes
//   bus      : switches_poller_if master modport (Avalon read + event channel)
//   irq      : only with SWITCHES_POLLER_IRQ_EN defined; evt_valid | evt_overflow
// Parameters: WIDTH (1..32), POLL_DIV (>=4) cycles per poll, DEBOUNCE_N (1..255).
// Optional feature macro: SWITCHES_POLLER_IRQ_EN.
module switches_poller
  import switches_poller_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int POLL_DIV   = 50000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  switches_poller_if.master bus
`ifdef SWITCHES_POLLER_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int                CNT_W     = $clog2(POLL_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(POLL_DIV - 1);

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick_s;
  poll_state_e      state_q, state_d;
  logic             avm_read_q, avm_read_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [WIDTH-1:0] stable_s, stable_next_s;
  logic             change_s, hs_s, unused_rd_s;
  logic             evt_valid_q, evt_valid_d, evt_overflow_q, evt_overflow_d;
  logic [WIDTH-1:0] evt_state_q, evt_state_d;
  logic [WIDTH-1:0] evt_rise_q, evt_rise_d, evt_fall_q, evt_fall_d;

  // Upper read-data bits above WIDTH carry no switches.
  assign unused_rd_s = ^bus.avm_readdata;

  // Poll tick divider: free-runs only while enabled.
  always_comb begin
    tick_s     = 1'b0;
    tick_cnt_d = tick_cnt_q;
    if (!enable) begin
      tick_cnt_d = {CNT_W{1'b0}};
    end else if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = {CNT_W{1'b0}};
      tick_s     = 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q + CNT_W'(1);
    end
  end

  // Poll FSM; a started sequence always runs to completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = tick_s ? READ : IDLE;
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = EVAL;
      EVAL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    avm_read_d = (state_d == READ);
    sample_d   = (state_q == CAPTURE) ? bus.avm_readdata[WIDTH-1:0] : sample_q;
  end

  switches_poller_debounce #(
    .WIDTH      (WIDTH),
    .DEBOUNCE_N (DEBOUNCE_N)
  ) u_debounce (
    .clk           (clk),
    .reset_n       (reset_n),
    .eval_i        (state_q == EVAL),
    .sample_i      (sample_q),
    .stable_o      (stable_s),
    .stable_next_o (stable_next_s),
    .change_o      (change_s)
  );

  assign hs_s = evt_valid_q & bus.evt_ready;

  // Event channel: fresh load, merge into pending, or consume.
  always_comb begin
    evt_valid_d    = evt_valid_q;
    evt_overflow_d = evt_overflow_q;
    evt_state_d    = evt_state_q;
    evt_rise_d     = evt_rise_q;
    evt_fall_d     = evt_fall_q;
    if (change_s) begin
      evt_state_d = stable_next_s;
      if (!evt_valid_q || hs_s) begin
        // Nothing pending after this edge: start a clean event.
        evt_valid_d = 1'b1;
        evt_rise_d  = stable_next_s & ~stable_s;
        evt_fall_d  = ~stable_next_s & stable_s;
      end else begin
        evt_rise_d     = evt_rise_q | (stable_next_s & ~stable_s);
        evt_fall_d     = evt_fall_q | (~stable_next_s & stable_s);
        evt_overflow_d = 1'b1;
      end
    end else if (hs_s) begin
      evt_valid_d    = 1'b0;
      evt_rise_d     = {WIDTH{1'b0}};
      evt_fall_d     = {WIDTH{1'b0}};
      evt_overflow_d = 1'b0;
    end else begin
      evt_valid_d = evt_valid_q;
    end
  end

  // Control, sample and event registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt_q     <= {CNT_W{1'b0}};
      state_q        <= IDLE;
      avm_read_q     <= 1'b0;
      sample_q       <= {WIDTH{1'b0}};
      evt_valid_q    <= 1'b0;
      evt_overflow_q <= 1'b0;
      evt_state_q    <= {WIDTH{1'b0}};
      evt_rise_q     <= {WIDTH{1'b0}};
      evt_fall_q     <= {WIDTH{1'b0}};
    end else begin
      tick_cnt_q     <= tick_cnt_d;
      state_q        <= state_d;
      avm_read_q     <= avm_read_d;
      sample_q       <= sample_d;
      evt_valid_q    <= evt_valid_d;
      evt_overflow_q <= evt_overflow_d;
      evt_state_q    <= evt_state_d;
      evt_rise_q     <= evt_rise_d;
      evt_fall_q     <= evt_fall_d;
    end
  end

`ifdef SWITCHES_POLLER_IRQ_EN
  logic irq_q;

  // Interrupt register, computed from next-state so it matches the event flags every cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= evt_valid_d | evt_overflow_d;
    end
  end

  assign irq = irq_q;
`endif

  assign bus.avm_address  = PIO_DATA_ADDR;
  assign bus.avm_read     = avm_read_q;
  assign bus.evt_valid    = evt_valid_q;
  assign bus.evt_state    = evt_state_q;
  assign bus.evt_rise     = evt_rise_q;
  assign bus.evt_fall     = evt_fall_q;
  assign bus.evt_overflow = evt_overflow_q;

endmodule

// File: tb/tb_switches_poller.sv
// tb_switches_poller
// Directed bench for switches_poller with POLL_DIV=4, DEBOUNCE_N=3, WIDTH=4
// and a one-cycle-latency PIO model. Define SWITCHES_POLLER_IRQ_EN to also
// cover the irq output.
module tb_switches_poller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [3:0] in_port;
  int         n_pass = 0;
  int         n_total = 0;
`ifdef SWITCHES_POLLER_IRQ_EN
  logic       irq;
`endif

  switches_poller_if #(.WIDTH(4)) bus ();

  switches_poller #(
    .WIDTH      (4),
    .POLL_DIV   (4),
    .DEBOUNCE_N (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .bus     (bus.master)
`ifdef SWITCHES_POLLER_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  always #5 clk = ~clk;

  // PIO model: data valid one cycle after the read strobe, junk in the upper bits.
  always @(posedge clk) begin
    bus.avm_readdata <= bus.avm_read ? {28'hA5A5A5A, in_port} : 32'h0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called at a negedge: returns at the negedge of a READ cycle (possibly the current one).
  task automatic wait_read();
    int i = 0;
    while (bus.avm_read !== 1'b1 && i < 20) begin
      @(negedge clk);
      i++;
    end
    if (i >= 20) begin
      n_total++;
      $display("FAIL poll_timeout: avm_read=%b required 1 within 20 cycles", bus.avm_read);
    end
  endtask

  // Run n complete polls; returns at the IDLE negedge after the last EVAL.
  task automatic poll(input int n);
    for (int k = 0; k < n; k++) begin
      wait_read();
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic handshake();
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; in_port = 4'b0000; bus.evt_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall, bus.evt_overflow} !== 14'b0)
      $display("FAIL reset_evt: got %b required %b",
               {bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall, bus.evt_overflow}, 14'b0);
    else n_pass++;
    n_total++;
    if ({bus.avm_read, bus.avm_address} !== 3'b000)
      $display("FAIL reset_avm: got %b required %b", {bus.avm_read, bus.avm_address}, 3'b000);
    else n_pass++;
`ifdef SWITCHES_POLLER_IRQ_EN
    n_total++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b required 0", irq);
    else n_pass++;
`endif
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tick();
    enable = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (bus.avm_read !== 1'b0) $display("FAIL tick_early: got %b required 0", bus.avm_read);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.avm_read !== 1'b1) $display("FAIL tick_first_read: got %b required 1", bus.avm_read);
    else n_pass++;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_total++;
      if (bus.avm_read !== (c == 4))
        $display("FAIL tick_period_c%0d: got %b required %b", c, bus.avm_read, (c == 4));
      else n_pass++;
    end
  endtask

  task automatic test_debounce_rise();
    in_port = 4'b0101;
    poll(2);
    n_total++;
    if (bus.evt_valid !== 1'b0) $display("FAIL rise_early: got %b required 0", bus.evt_valid);
    else n_pass++;
    poll(1);
    n_total++;
    if ({bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall, bus.evt_overflow} !== 14'b1_0101_0101_0000_0)
      $display("FAIL rise_event: got %b required %b",
               {bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall, bus.evt_overflow},
               14'b1_0101_0101_0000_0);
    else n_pass++;
    handshake();
    n_total++;
    if ({bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall} !== 13'b0_0101_0000_0000)
      $display("FAIL rise_consume: got %b required %b",
               {bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall}, 13'b0_0101_0000_0000);
    else n_pass++;
  endtask

  task automatic test_glitch();
    in_port = 4'b0111;
    poll(2);
    in_port = 4'b0101;
    poll(1);
    n_total++;
    if (dut.u_debounce.count_q !== 8'd0)
      $display("FAIL glitch_count: got %0d required 0", dut.u_debounce.count_q);
    else n_pass++;
    poll(2);
    n_total++;
    if ({bus.evt_valid, bus.evt_state} !== 5'b0_0101)
      $display("FAIL glitch_no_event: got %b required %b", {bus.evt_valid, bus.evt_state}, 5'b0_0101);
    else n_pass++;
  endtask

  task automatic test_overflow();
    in_port = 4'b0000;
    poll(3);
    n_total++;
    if ({bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall} !== 13'b1_0000_0000_0101)
      $display("FAIL fall_event: got %b required %b",
               {bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall}, 13'b1_0000_0000_0101);
    else n_pass++;
    handshake();
    in_port = 4'b0001;
    poll(3);
    n_total++;
    if ({bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_overflow} !== 10'b1_0001_0001_0)
      $display("FAIL ovf_first: got %b required %b",
               {bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_overflow}, 10'b1_0001_0001_0);
    else n_pass++;
    in_port = 4'b0011;
    poll(3);
    n_total++;
    if ({bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall, bus.evt_overflow} !== 14'b1_0011_0011_0000_1)
      $display("FAIL ovf_merged: got %b required %b",
               {bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall, bus.evt_overflow},
               14'b1_0011_0011_0000_1);
    else n_pass++;
`ifdef SWITCHES_POLLER_IRQ_EN
    n_total++;
    if (irq !== 1'b1) $display("FAIL ovf_irq_set: got %b required 1", irq);
    else n_pass++;
`endif
    handshake();
    n_total++;
    if ({bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall, bus.evt_overflow} !== 14'b0_0011_0000_0000_0)
      $display("FAIL ovf_consume: got %b required %b",
               {bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall, bus.evt_overflow},
               14'b0_0011_0000_0000_0);
    else n_pass++;
`ifdef SWITCHES_POLLER_IRQ_EN
    n_total++;
    if (irq !== 1'b0) $display("FAIL ovf_irq_clear: got %b required 0", irq);
    else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    in_port = 4'b0010;
    poll(3);
    n_total++;
    if ({bus.evt_valid, bus.evt_fall} !== 5'b1_0001)
      $display("FAIL b2b_first: got %b required %b", {bus.evt_valid, bus.evt_fall}, 5'b1_0001);
    else n_pass++;
    in_port = 4'b1010;
    poll(2);
    wait_read();
    @(negedge clk);          // CAPTURE
    @(negedge clk);          // EVAL: consume while the new change is generated
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
    n_total++;
    if ({bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall, bus.evt_overflow} !== 14'b1_1010_1000_0000_0)
      $display("FAIL b2b_fresh: got %b required %b",
               {bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall, bus.evt_overflow},
               14'b1_1010_1000_0000_0);
    else n_pass++;
    handshake();
  endtask

  task automatic test_enable_drop();
    int reads = 0;
    in_port = 4'b1111;
    wait_read();
    enable = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (dut.u_debounce.count_q !== 8'd1)
      $display("FAIL endrop_completed: got count %0d required 1", dut.u_debounce.count_q);
    else n_pass++;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.avm_read === 1'b1) reads++;
    end
    n_total++;
    if (reads !== 0) $display("FAIL endrop_idle: got %0d reads required 0", reads);
    else n_pass++;
    n_total++;
    if ({bus.evt_valid, bus.evt_state} !== 5'b0_1010)
      $display("FAIL endrop_evt: got %b required %b", {bus.evt_valid, bus.evt_state}, 5'b0_1010);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    poll(2);
    n_total++;
    if ({bus.evt_valid, bus.evt_state, bus.evt_rise} !== 9'b1_1111_0101)
      $display("FAIL rmid_pending: got %b required %b",
               {bus.evt_valid, bus.evt_state, bus.evt_rise}, 9'b1_1111_0101);
    else n_pass++;
    wait_read();
    @(negedge clk);          // CAPTURE with 1111 on readdata
    reset_n = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall, bus.evt_overflow, bus.avm_read} !== 15'b0)
      $display("FAIL rmid_outputs: got %b required %b",
               {bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall, bus.evt_overflow, bus.avm_read}, 15'b0);
    else n_pass++;
    n_total++;
    if ({dut.sample_q, dut.u_debounce.count_q} !== 12'b0)
      $display("FAIL rmid_internal: got %b required %b", {dut.sample_q, dut.u_debounce.count_q}, 12'b0);
    else n_pass++;
`ifdef SWITCHES_POLLER_IRQ_EN
    n_total++;
    if (irq !== 1'b0) $display("FAIL rmid_irq: got %b required 0", irq);
    else n_pass++;
`endif
    reset_n = 1'b1;
    in_port = 4'b0000;
    poll(3);
    n_total++;
    if ({bus.evt_valid, bus.evt_state} !== 5'b0)
      $display("FAIL rmid_no_event: got %b required %b", {bus.evt_valid, bus.evt_state}, 5'b0);
    else n_pass++;
  endtask

  task automatic test_power_up_high();
    in_port = 4'b1100;
    poll(2);
    n_total++;
    if (bus.evt_valid !== 1'b0) $display("FAIL pup_early: got %b required 0", bus.evt_valid);
    else n_pass++;
    poll(1);
    n_total++;
    if ({bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall, bus.evt_overflow} !== 14'b1_1100_1100_0000_0)
      $display("FAIL pup_event: got %b required %b",
               {bus.evt_valid, bus.evt_state, bus.evt_rise, bus.evt_fall, bus.evt_overflow},
               14'b1_1100_1100_0000_0);
    else n_pass++;
`ifdef SWITCHES_POLLER_IRQ_EN
    n_total++;
    if (irq !== 1'b1) $display("FAIL pup_irq: got %b required 1", irq);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_tick();
    test_debounce_rise();
    test_glitch();
    test_overflow();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    test_power_up_high();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/switches_poller.md
SWITCHES_POLLER -- requirements
Module: switches_poller

Interface
REQ-001 Parameter WIDTH, default 4, number of switch bits sampled (1..32).
REQ-002 Parameter POLL_DIV, default 50000, clk cycles between poll reads (>=4).
REQ-003 Parameter DEBOUNCE_N, default 4, consecutive identical polls required to accept a change (1..255).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 enable  in  1  polling enable; low holds FSM in IDLE.
REQ-007 avm_address  out  2  Avalon-MM master address to switches PIO; constant 0.
REQ-008 avm_read  out  1  Avalon-MM read strobe, one-cycle pulse.
REQ-009 avm_readdata  in  32  PIO read data, valid exactly 1 cycle after avm_read.
REQ-010 evt_valid  out  1  debounced change event pending.
REQ-011 evt_ready  in  1  consumer accepts event when evt_valid & evt_ready.
REQ-012 evt_state  out  WIDTH  debounced switch state after latest accepted change.
REQ-013 evt_rise  out  WIDTH  bits that went 0->1 since last handshake.
REQ-014 evt_fall  out  WIDTH  bits that went 1->0 since last handshake.
REQ-015 evt_overflow  out  1  sticky: a change merged into an unconsumed event.

Function
REQ-016 Tick counter SHALL count 0..POLL_DIV-1 while enable=1, pulse tick at POLL_DIV-1, then wrap to 0; enable=0 clears it.
REQ-017 FSM states IDLE, READ, CAPTURE, EVAL; IDLE->READ on tick; READ->CAPTURE; CAPTURE->EVAL; EVAL->IDLE, each one cycle.
REQ-018 avm_read SHALL be 1 only in READ; sample = avm_readdata[WIDTH-1:0] registered in CAPTURE; upper bits ignored.
REQ-019 In EVAL: sample==stable -> count cleared; sample!=stable and sample==candidate -> count+1; sample!=candidate -> candidate<=sample, count<=1.
REQ-020 When count reaches DEBOUNCE_N in EVAL, stable<=candidate, count<=0, change event generated that cycle.
REQ-021 Event generation with evt_valid=0: evt_state<=new stable, evt_rise<=new&~old, evt_fall<=~new&old, evt_valid<=1 next cycle.
REQ-022 Event generation with evt_valid=1 and no handshake same cycle: evt_state updated, rise/fall OR-accumulated, evt_overflow<=1.
REQ-023 Handshake and generation in same cycle: pending event consumed, new event loaded fresh per REQ-021, evt_overflow unchanged.
REQ-024 Handshake alone: evt_valid<=0, evt_rise/evt_fall<=0, evt_overflow<=0; evt_state held.
REQ-025 A bit toggling back to original before DEBOUNCE_N polls SHALL produce no event.
REQ-026 enable falling mid-sequence SHALL let READ/CAPTURE/EVAL complete, then remain IDLE; event outputs unaffected.

Reset
REQ-027 reset_n=0 at a rising edge SHALL set: FSM IDLE, tick counter 0, avm_read 0, stable/candidate/sample 0, count 0, evt_valid 0, evt_state/evt_rise/evt_fall 0, evt_overflow 0, irq 0.
REQ-028 Reset mid-sequence SHALL abort any in-flight read; readdata arriving next cycle SHALL be ignored.
REQ-029 First accepted state after reset compares against stable=0; switches high at reset produce one rise event after DEBOUNCE_N polls.

Configuration
REQ-030 Macro SWITCHES_POLLER_IRQ_EN defined: output irq (1 bit) registered, equal to evt_valid | evt_overflow, cleared on handshake per REQ-024.
REQ-031 Macro undefined: port irq absent; all other behaviour identical.

Structure
REQ-032 Shared package switches_poller_pkg SHALL hold FSM state enum (IDLE, READ, CAPTURE, EVAL) and constant PIO_DATA_ADDR=2'd0.
REQ-033 One sub-module switches_poller_debounce (REQ-019..020, candidate/stable/count) natural; FSM, tick, event logic in top.

Verification
REQ-034 POLL_DIV=4, DEBOUNCE_N=3, PIO model latency 1; in_port 0->4'b0101 held -> one event after 3 polls: state 0101, rise 0101, fall 0000.
REQ-035 4'b0101 glitch to 4'b0111 for 2 polls then back -> no event, count cleared.
REQ-036 evt_ready=0; changes 0000->0001 then ->0011 (debounced) -> evt_state 0011, evt_rise 0011, evt_overflow=1; evt_ready=1 one cycle -> all cleared, state held.
REQ-037 Handshake in same cycle as new generation -> new event only, evt_overflow stays 0, evt_valid stays 1.
REQ-038 Assert reset_n=0 during CAPTURE with readdata=4'b1111 -> all outputs 0 next cycle, avm_read 0, no event.
REQ-039 SWITCHES_POLLER_IRQ_EN defined: irq tracks evt_valid|evt_overflow cycle-exact; undefined build elaborates without irq.
